mcu_el2_dccm_arb: RTL
=====================

# mcu_el2_dccm_arb

Two-requester arbiter that shares the single-ported DCCM bank array between the LSU pipe and the DMA slave port. It issues one access per cycle to the DCCM memory block, tags each read so its data returns one cycle later to the correct owner, and enforces a bounded DMA wait via a starvation counter. It sits between the LSU/DMA request logic and the DCCM memory datapath.

## Interface
- DCCM_BITS, 16, byte-address width of the DCCM.
- DCCM_FDATA_WIDTH, 39, data plus ECC width per access.
- DMA_MAX_STALL, 7, consecutive blocked DMA cycles before DMA is forced; legal range 1..255.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- lsu_req  in  1  LSU access request; payload held stable until lsu_gnt.
- lsu_wr  in  1  1 = write, 0 = read.
- lsu_addr  in  DCCM_BITS  LSU address.
- lsu_wdata  in  DCCM_FDATA_WIDTH  LSU write data.
- lsu_gnt  out  1  LSU request accepted this cycle.
- dma_req, dma_wr, dma_addr, dma_wdata  in  1/1/DCCM_BITS/DCCM_FDATA_WIDTH  DMA request, same rules as LSU.
- dma_gnt  out  1  DMA request accepted this cycle.
- dccm_wren, dccm_rden  out  1  write/read enable to the DCCM memory block.
- dccm_addr  out  DCCM_BITS  access address.
- dccm_wdata  out  DCCM_FDATA_WIDTH  write data.
- dccm_rdata  in  DCCM_FDATA_WIDTH  read data, valid one cycle after dccm_rden.
- rsp_valid  out  1  read data valid.
- rsp_dma  out  1  owner of rsp_valid: 0 = LSU, 1 = DMA.
- rsp_rdata  out  DCCM_FDATA_WIDTH  read data returned.
- dma_forced  out  1  pulse: current grant was issued by starvation override.

## Operation
- FSM states: LSU_PRI (reset), DMA_FORCE.
- LSU_PRI: lsu_req wins; dma_gnt = dma_req & ~lsu_req.
- DMA_FORCE: dma_req wins; lsu_gnt = lsu_req & ~dma_req; dma_forced = dma_gnt.
- At most one grant per cycle; lsu_gnt & dma_gnt is never 1.
- dccm_wren = granted & wr; dccm_rden = granted & ~wr; dccm_addr/dccm_wdata mux the granted requester; all zero when no grant.
- stall_cnt (8 bits): +1 when dma_req & ~dma_gnt, saturating at DMA_MAX_STALL; cleared when dma_gnt or ~dma_req.
- LSU_PRI -> DMA_FORCE when next stall_cnt == DMA_MAX_STALL. DMA_FORCE -> LSU_PRI on dma_gnt, or when dma_req drops (request withdrawn; counter clears).
- Response pipe: flop rsp_valid_q = dccm_rden, rsp_dma_q = dma_gnt; rsp_valid = rsp_valid_q, rsp_dma = rsp_dma_q, rsp_rdata = dccm_rdata gated to zero when ~rsp_valid_q.
- Writes generate no response.

## Timing
- Grant is combinational, same cycle as request; DCCM access issued in the grant cycle.
- Read data: rsp_valid exactly 1 cycle after grant; back-to-back reads give back-to-back responses, no bubbles.
- Worst-case DMA wait with continuous LSU traffic: DMA_MAX_STALL cycles, grant on cycle DMA_MAX_STALL+1.
- Reset: state = LSU_PRI, stall_cnt = 0, rsp_valid = 0, rsp_dma = 0, rsp_rdata = 0, dma_forced = 0; gnt and dccm enables are 0 while rst is high.
- Reset mid-read: pending response is dropped; no rsp_valid after release.
- Simultaneous requests in the cycle stall_cnt saturates: that cycle LSU still wins; DMA wins the next cycle.

## Configuration
- MCU_DCCM_ARB_FAIRNESS_EN defined: starvation counter and DMA_FORCE state present as above.
- Not defined: strict LSU priority, stall_cnt and FSM removed, dma_forced tied 0; DMA may starve indefinitely.

## Test plan
- Single LSU read addr 0x0040 -> lsu_gnt, dccm_rden=1, addr 0x0040 same cycle; next cycle rsp_valid=1, rsp_dma=0, rsp_rdata=dccm_rdata.
- DMA write 0x0100, data 0x12345678 with no LSU -> dma_gnt, dccm_wren=1, dccm_wdata matches; no rsp_valid.
- DMA_MAX_STALL=3, LSU and DMA read continuously -> LSU granted cycles 0-2, DMA cycle 3 with dma_forced=1, LSU cycle 4; rsp_dma=1 in cycle 4.
- Same stimulus without MCU_DCCM_ARB_FAIRNESS_EN -> dma_gnt never asserts over 100 cycles.
- DMA withdraws request at stall_cnt=2 -> stall_cnt clears, FSM stays LSU_PRI, next DMA waits full 3 cycles again.
- Assert rst the cycle after a granted LSU read -> rsp_valid stays 0, all outputs 0, LSU_PRI after release.

Source files
------------

// File: rtl/mcu_el2_dccm_arb.sv
// LSU/DMA arbiter for the single-ported DCCM: one access per cycle, read responses tagged by owner.
// Optional starvation override for DMA is compiled in with `define MCU_DCCM_ARB_FAIRNESS_EN.
//
//   state     | meaning
//   LSU_PRI   | LSU wins simultaneous requests; DMA blocked cycles are counted
//   DMA_FORCE | DMA wins simultaneous requests (starvation override)
module mcu_el2_dccm_arb #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DMA_MAX_STALL    = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lsu_req,
  input  logic                        lsu_wr,
  input  logic [DCCM_BITS-1:0]        lsu_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata,
  output logic                        lsu_gnt,
  input  logic                        dma_req,
  input  logic                        dma_wr,
  input  logic [DCCM_BITS-1:0]        dma_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
  output logic                        dma_gnt,
  output logic                        dccm_wren,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_addr,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wdata,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rdata,
  output logic                        rsp_valid,
  output logic                        rsp_dma,
  output logic [DCCM_FDATA_WIDTH-1:0] rsp_rdata,
  output logic                        dma_forced
);

  logic dma_win;
  logic rsp_valid_q;
  logic rsp_dma_q;

`ifdef MCU_DCCM_ARB_FAIRNESS_EN
  typedef enum logic {LSU_PRI = 1'b0, DMA_FORCE = 1'b1} state_t;

  localparam logic [7:0] MaxStall = 8'(DMA_MAX_STALL);

  state_t     state_q, state_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_PRI;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Counts consecutive cycles DMA is requesting but not granted; any grant or withdrawal clears it.
  always_comb begin
    stall_cnt_d = 8'd0;
    if (dma_req && !dma_gnt) begin
      stall_cnt_d = (stall_cnt_q >= MaxStall) ? MaxStall : stall_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_PRI:   if (stall_cnt_d == MaxStall) state_d = DMA_FORCE;
      DMA_FORCE: if (dma_gnt || !dma_req)     state_d = LSU_PRI;
      default:   state_d = LSU_PRI;
    endcase
  end

  always_comb begin
    dma_win    = (state_q == DMA_FORCE);
    dma_forced = dma_win & dma_gnt;
  end
`else
  assign dma_win    = 1'b0;
  assign dma_forced = 1'b0;
`endif

  // Grants are suppressed while reset is held so no access leaks out during reset.
  always_comb begin
    lsu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      if (dma_win) begin
        dma_gnt = dma_req;
        lsu_gnt = lsu_req & ~dma_req;
      end else begin
        lsu_gnt = lsu_req;
        dma_gnt = dma_req & ~lsu_req;
      end
    end
  end

  always_comb begin
    dccm_wren  = 1'b0;
    dccm_rden  = 1'b0;
    dccm_addr  = '0;
    dccm_wdata = '0;
    if (lsu_gnt) begin
      dccm_wren  = lsu_wr;
      dccm_rden  = ~lsu_wr;
      dccm_addr  = lsu_addr;
      dccm_wdata = lsu_wdata;
    end else if (dma_gnt) begin
      dccm_wren  = dma_wr;
      dccm_rden  = ~dma_wr;
      dccm_addr  = dma_addr;
      dccm_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_dma_q   <= 1'b0;
    end else begin
      rsp_valid_q <= dccm_rden;
      rsp_dma_q   <= dma_gnt;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_dma   = rsp_dma_q;
  assign rsp_rdata = rsp_valid_q ? dccm_rdata : '0;

endmodule
